// File: rtl/cu_pkg.sv
// Shared encodings for the multi-cycle RV32 control unit: FSM states,
// opcodes, ALU operations and datapath mux selects.
package cu_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b001;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_OR  = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b111;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   // States that own the shared memory port and may wait on it
   function automatic logic is_mem_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from funct3 / funct7[5]; shared with the pipelined core.
module alu_decoder
   import cu_pkg::*;
(
   input  logic       op5,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alu_control
);

   // Subtract only for R-type with funct7[5] set; slt/sltu fall back to add
   always_comb begin
      alu_control = ALU_ADD;
      case (funct3)
         3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_control = ALU_SLL;
         3'b100:  alu_control = ALU_XOR;
         3'b101:  alu_control = ALU_SRL;
         3'b110:  alu_control = ALU_OR;
         3'b111:  alu_control = ALU_AND;
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle RV32 control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback over a shared memory port with a bounded wait counter.
module multicycle_cu
   import cu_pkg::*;
#(
   parameter bit WAIT_EN  = 1'b1,
   parameter int WAIT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        zf,
   input  logic        sf,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_write,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  imm_src,
   output logic [2:0]  alu_control,
   output logic [1:0]  result_src,
   output logic        illegal,
   output logic        timeout,
   output logic [3:0]  state_o
);

   localparam int CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [2:0]       alu_dec_ctl;
   logic             ready_eff;
   logic             at_limit;
   logic             unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
   assign ready_eff    = mem_ready | ~WAIT_EN;
   // Ready on the limit cycle wins over the abort
   assign at_limit     = (WAIT_MAX > 0) && !ready_eff && (cnt == WAIT_LIM);
   assign state_o      = state;

   alu_decoder u_alu_dec (
      .op5        (instr[5]),
      .funct3     (funct3),
      .funct7b5   (instr[30]),
      .alu_control(alu_dec_ctl)
   );

   // State register and wait counter; counter only runs while a memory state stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (is_mem_state(state) && !ready_eff && !at_limit) cnt <= cnt + 1'b1;
         else                                                 cnt <= '0;
      end
   end

   // Next-state and datapath controls; an aborted access drops its request and enables
   always_comb begin
      state_nx    = state;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = SRCA_PC;
      alu_src_b   = SRCB_RS2;
      imm_src     = IMM_I;
      alu_control = ALU_ADD;
      result_src  = RES_ALUOUT;
      illegal     = 1'b0;
      timeout     = 1'b0;
      case (state)
         S_FETCH: begin
            if (at_limit) begin
               timeout  = 1'b1;
               state_nx = S_FETCH;
            end else begin
               mem_req = 1'b1;
               if (ready_eff) begin
                  ir_write   = 1'b1;
                  pc_write   = 1'b1;
                  alu_src_b  = SRCB_FOUR;
                  result_src = RES_ALU;
                  state_nx   = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
            case (opcode)
               OP_LOAD, OP_STORE: state_nx = S_MEMADR;
               OP_RTYPE:          state_nx = S_EXECR;
               OP_ITYPE:          state_nx = S_EXECI;
               OP_BRANCH:         state_nx = S_BRANCH;
               OP_JAL:            state_nx = S_JAL;
               default: begin
                  illegal  = 1'b1;
                  state_nx = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
            state_nx  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD, S_MEMWRITE: begin
            adr_src = 1'b1;
            if (at_limit) begin
               timeout  = 1'b1;
               state_nx = S_FETCH;
            end else begin
               mem_req   = 1'b1;
               mem_write = (state == S_MEMWRITE);
               if (ready_eff) state_nx = (state == S_MEMREAD) ? S_MEMWB : S_FETCH;
            end
         end
         S_MEMWB: begin
            result_src = RES_MEM;
            reg_write  = 1'b1;
            state_nx   = S_FETCH;
         end
         S_EXECR, S_EXECI: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
            alu_control = alu_dec_ctl;
            state_nx    = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            state_nx   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a   = SRCA_RS1;
            alu_src_b   = SRCB_RS2;
            alu_control = ALU_SUB;
            case (funct3)
               3'b000:  pc_write = zf;
               3'b001:  pc_write = ~zf;
               3'b100:  pc_write = sf;
               default: pc_write = 1'b0;
            endcase
            state_nx = S_FETCH;
         end
         S_JAL: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_FOUR;
            pc_write  = 1'b1;
            state_nx  = S_ALUWB;
         end
         default: state_nx = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: per-cycle comparison against an
// instruction-level reference model, plus directed CPI and reset scenarios.
module tb_multicycle_cu;
   import cu_pkg::*;

   localparam int WMAX = 3;

   logic        clk = 1'b0;
   logic        rst, zf, sf, mem_ready;
   logic [31:0] instr;
   logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
   logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
   logic [2:0]  alu_control;
   logic        illegal, timeout;
   logic [3:0]  state_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0] st;
      logic       req, wr, adr, irw, pcw, rw;
      logic [1:0] sa, sb, imm;
      logic [2:0] alu;
      logic [1:0] res;
      logic       ill, to;
   } obs_t;

   obs_t exp_q[$];
   logic rdy_q[$];

   multicycle_cu #(.WAIT_EN(1'b1), .WAIT_MAX(WMAX)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zf(zf), .sf(sf), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
      .result_src(result_src), .illegal(illegal), .timeout(timeout), .state_o(state_o)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t o;
      o.st = state_o; o.req = mem_req; o.wr = mem_write; o.adr = adr_src;
      o.irw = ir_write; o.pcw = pc_write; o.rw = reg_write;
      o.sa = alu_src_a; o.sb = alu_src_b; o.imm = imm_src;
      o.alu = alu_control; o.res = result_src; o.ill = illegal; o.to = timeout;
      return o;
   endfunction

   function automatic bit legal_op(logic [6:0] op);
      return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL};
   endfunction

   function automatic void push(obs_t o, logic r);
      exp_q.push_back(o);
      rdy_q.push_back(r);
   endfunction

   // One memory access that is ready after d stalled cycles; returns 0 if it aborts
   function automatic bit mem_phase(logic [3:0] st, int d, bit is_fetch, bit is_write);
      obs_t o;
      for (int i = 0; i <= WMAX; i++) begin
         o = '0;
         o.st  = st;
         o.adr = !is_fetch;
         if (i == d) begin
            o.req = 1'b1; o.wr = is_write;
            if (is_fetch) begin
               o.irw = 1'b1; o.pcw = 1'b1; o.sb = 2'b10; o.res = 2'b10;
            end
            push(o, 1'b1);
            return 1'b1;
         end else if (i == WMAX) begin
            o.to = 1'b1;
            push(o, 1'b0);
            return 1'b0;
         end else begin
            o.req = 1'b1; o.wr = is_write;
            push(o, 1'b0);
         end
      end
      return 1'b0;
   endfunction

   function automatic logic [2:0] exp_alu(logic [31:0] w);
      logic [2:0] f3;
      f3 = w[14:12];
      if (f3 == 3'b000) return (w[6:0] == OP_RTYPE && w[30]) ? 3'b010 : 3'b000;
      if (f3 == 3'b010 || f3 == 3'b011) return 3'b000;
      return f3;
   endfunction

   // Expected cycle-by-cycle behaviour of one instruction from the ISA-level rules
   function automatic void model_instr(logic [31:0] w, int df, int dm, logic z, logic s);
      obs_t o;
      logic [6:0] op;
      logic [2:0] f3;
      op = w[6:0];
      f3 = w[14:12];
      if (!mem_phase(S_FETCH, df, 1'b1, 1'b0)) void'(mem_phase(S_FETCH, 0, 1'b1, 1'b0));
      o = '0; o.st = S_DECODE; o.sa = 2'b01; o.sb = 2'b01;
      o.imm = (op == OP_JAL) ? 2'b11 : 2'b10;
      o.ill = !legal_op(op);
      push(o, 1'($urandom));
      if (!legal_op(op)) return;
      o = '0;
      if (op == OP_LOAD || op == OP_STORE) begin
         o.st = S_MEMADR; o.sa = 2'b10; o.sb = 2'b01;
         o.imm = (op == OP_STORE) ? 2'b01 : 2'b00;
         push(o, 1'($urandom));
         if (op == OP_STORE) void'(mem_phase(S_MEMWRITE, dm, 1'b0, 1'b1));
         else if (mem_phase(S_MEMREAD, dm, 1'b0, 1'b0)) begin
            o = '0; o.st = S_MEMWB; o.res = 2'b01; o.rw = 1'b1;
            push(o, 1'($urandom));
         end
         return;
      end
      if (op == OP_BRANCH) begin
         o.st = S_BRANCH; o.sa = 2'b10; o.alu = 3'b010;
         o.pcw = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : (f3 == 3'b100) ? s : 1'b0;
         push(o, 1'($urandom));
         return;
      end
      if (op == OP_JAL) begin
         o.st = S_JAL; o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1'b1;
      end else begin
         o.st = (op == OP_RTYPE) ? S_EXECR : S_EXECI;
         o.sa = 2'b10; o.sb = (op == OP_RTYPE) ? 2'b00 : 2'b01;
         o.alu = exp_alu(w);
      end
      push(o, 1'($urandom));
      o = '0; o.st = S_ALUWB; o.rw = 1'b1;
      push(o, 1'($urandom));
   endfunction

   task automatic run_instr(input logic [31:0] w, input int df, input int dm,
                            input logic z, input logic s, input string name);
      obs_t got;
      exp_q.delete();
      rdy_q.delete();
      model_instr(w, df, dm, z, s);
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         instr = w; zf = z; sf = s; mem_ready = rdy_q[i];
         #1;
         got = sample();
         checks++;
         if (got !== exp_q[i]) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp_q[i]);
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (state_o !== S_FETCH) begin
         errors++;
         $display("FAIL %s end_state: got %0d expected %0d", name, state_o, S_FETCH);
      end
   endtask

   function automatic logic [31:0] rand_instr(int cls);
      logic [31:0] w;
      logic [6:0]  op;
      w = $urandom;
      case (cls)
         0: op = OP_LOAD;
         1: op = OP_STORE;
         2: op = OP_RTYPE;
         3: op = OP_ITYPE;
         4: op = OP_BRANCH;
         5: op = OP_JAL;
         default: begin
            op = 7'($urandom);
            while (legal_op(op)) op = 7'($urandom);
         end
      endcase
      w[6:0] = op;
      return w;
   endfunction

   task automatic test_reset();
      rst = 1'b1; instr = '0; zf = 1'b0; sf = 1'b0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (state_o !== S_FETCH || mem_req !== 1'b1 || adr_src !== 1'b0 || illegal !== 1'b0 ||
          timeout !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset: state %0d req %b adr %b ill %b to %b rw %b wr %b expected 0 1 0 0 0 0 0",
                  state_o, mem_req, adr_src, illegal, timeout, reg_write, mem_write);
      end
      rst = 1'b0;
   endtask

   task automatic test_load_wait();
      run_instr({12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011}, 2, 2, 1'b0, 1'b0, "lw_wait");
   endtask

   task automatic test_alu();
      run_instr({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 0, 1'b0, 1'b0, "sub");
      run_instr({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 0, 0, 1'b0, 1'b0, "add");
      run_instr({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011}, 0, 0, 1'b0, 1'b0, "addi_b30");
      run_instr({7'b0000000, 5'd2, 5'd1, 3'b111, 5'd3, 7'b0110011}, 1, 0, 1'b0, 1'b0, "and");
   endtask

   task automatic test_branch();
      run_instr({7'b0, 5'd2, 5'd1, 3'b000, 5'b0, 7'b1100011}, 0, 0, 1'b1, 1'b0, "beq_taken");
      run_instr({7'b0, 5'd2, 5'd1, 3'b001, 5'b0, 7'b1100011}, 0, 0, 1'b1, 1'b0, "bne_not");
      run_instr({7'b0, 5'd2, 5'd1, 3'b100, 5'b0, 7'b1100011}, 0, 0, 1'b0, 1'b1, "blt_taken");
      run_instr({7'b0, 5'd2, 5'd1, 3'b110, 5'b0, 7'b1100011}, 0, 0, 1'b1, 1'b1, "bltu_none");
   endtask

   task automatic test_timeout();
      run_instr({7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 0, WMAX + 1, 1'b0, 1'b0, "sw_abort");
      run_instr({7'b0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011}, 0, WMAX, 1'b0, 1'b0, "sw_limit_ready");
      run_instr({12'd4, 5'd1, 3'b010, 5'd6, 7'b0000011}, 0, WMAX + 2, 1'b0, 1'b0, "lw_abort");
      run_instr({7'b0, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, WMAX + 1, 0, 1'b0, 1'b0, "fetch_abort");
   endtask

   task automatic test_illegal();
      run_instr({20'h12345, 5'd7, 7'b0110111}, 0, 0, 1'b0, 1'b0, "lui_illegal");
   endtask

   task automatic test_cpi();
      int exp_cpi[6] = '{5, 4, 4, 4, 3, 4};
      int n;
      for (int c = 0; c < 6; c++) begin
         instr = rand_instr(c); mem_ready = 1'b1; zf = 1'(c); sf = 1'b0;
         n = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (state_o !== S_FETCH && n < 20);
         checks++;
         if (n !== exp_cpi[c]) begin
            errors++;
            $display("FAIL cpi class %0d: got %0d cycles expected %0d", c, n, exp_cpi[c]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      w = {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011};
      @(negedge clk); instr = w; mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (state_o !== S_MEMREAD || mem_req !== 1'b1 || adr_src !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: state %0d req %b adr %b expected %0d 1 1",
                  state_o, mem_req, adr_src, S_MEMREAD);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (state_o !== S_FETCH || mem_req !== 1'b1 || adr_src !== 1'b0 ||
          mem_write !== 1'b0 || reg_write !== 1'b0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid: state %0d req %b adr %b wr %b rw %b to %b expected %0d 1 0 0 0 0",
                  state_o, mem_req, adr_src, mem_write, reg_write, timeout, S_FETCH);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      int cls;
      for (int k = 0; k < 40; k++) begin
         cls = $urandom_range(0, 6);
         run_instr(rand_instr(cls), $urandom_range(0, WMAX + 1), $urandom_range(0, WMAX + 2),
                   1'($urandom), 1'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_load_wait();
      test_alu();
      test_branch();
      test_timeout();
      test_illegal();
      test_cpi();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
Multi-cycle control unit for the RV32 datapath, replacing the single-cycle decoder once fetch and data memory share one port with wait states. A Moore FSM sequences fetch, decode, execute, memory and writeback, and drives datapath mux selects and register enables. A bounded wait counter on the memory handshake adds a timeout. Sits between the instruction register (IR), the ALU flags and the unified memory port.

Parameters:
WAIT_EN, 1, 1 = honour mem_ready; 0 = memory treated as always ready
WAIT_MAX, 15, max wait cycles per memory access before abort; 0 = no timeout
CNT_W, $clog2(WAIT_MAX+1) (min 1), wait counter width (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
instr  input  32  IR contents, stable from DECODE onward
zf  input  1  ALU zero flag (combinational, current cycle)
sf  input  1  ALU sign flag
mem_ready  input  1  memory completes access this cycle
mem_req  output  1  memory access request
mem_write  output  1  write qualifier for mem_req
adr_src  output  1  0 = PC, 1 = ALUOut
ir_write  output  1  load IR and OldPC
pc_write  output  1  PC enable
reg_write  output  1  register file write enable
alu_src_a  output  2  00 PC, 01 OldPC, 10 rs1
alu_src_b  output  2  00 rs2, 01 imm, 10 const 4
imm_src  output  2  00 I, 01 S, 10 B, 11 J
alu_control  output  3  000 add, 010 sub, 001 sll, 100 xor, 101 srl, 110 or, 111 and
result_src  output  2  00 ALUOut, 01 mem data, 10 ALU result
illegal  output  1  one-cycle pulse on unknown opcode
timeout  output  1  one-cycle pulse on memory wait abort
state_o  output  4  current state, for debug

Behaviour:
- Reset: state FETCH, counter 0, illegal = timeout = 0. All outputs are combinational from state, instr, flags and mem_ready. Every output not listed for a state is 0.
- FETCH: mem_req = 1, adr_src = 0. While mem_ready = 0, hold state and increment counter. On ready: ir_write = 1, pc_write = 1, alu_src_a = 00, alu_src_b = 10, add, result_src = 10, go to DECODE.
- DECODE: alu_src_a = 01, alu_src_b = 01, add, imm_src = B (imm_src = J if opcode is 1101111).
  - Opcode 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - Any other opcode -> FETCH with illegal = 1.
- MEMADR: alu_src_a = 10, alu_src_b = 01, add; imm_src = I for load, S for store. Next state MEMREAD for load, MEMWRITE for store.
- MEMREAD: mem_req = 1, adr_src = 1. Wait as in FETCH; on ready -> MEMWB.
- MEMWB: result_src = 01, reg_write = 1 -> FETCH.
- MEMWRITE: mem_req = 1, mem_write = 1, adr_src = 1. On ready -> FETCH.
- EXECR / EXECI: alu_src_a = 10; alu_src_b = 00 (EXECR) or 01 with imm_src = I (EXECI). Then -> ALUWB.
- ALU decode (EXECR/EXECI), by funct3:
  - 000: sub only if opcode[5] = 1 and instr[30] = 1, else add.
  - 001 sll, 100 xor, 101 srl, 110 or, 111 and.
  - 010/011: add.
- ALUWB: result_src = 00, reg_write = 1 -> FETCH.
- BRANCH: alu_src_a = 10, alu_src_b = 00, sub, result_src = 00. pc_write is asserted by funct3:
  - 000 (beq): pc_write = zf.
  - 001 (bne): pc_write = ~zf.
  - 100 (blt): pc_write = sf.
  - Other funct3: pc_write = 0.
  - Then -> FETCH.
- JAL: alu_src_a = 01, alu_src_b = 10, add, result_src = 00, pc_write = 1 (PC takes the target held in ALUOut) -> ALUWB, which writes OldPC + 4.
- Wait counter: clears on entering any memory state and on completion. If WAIT_MAX > 0 and counter == WAIT_MAX with mem_ready = 0: timeout = 1, mem_req drops, state -> FETCH. No PC, IR or register update occurs on abort.
- mem_ready arriving on the same cycle as the limit counts as completion, not timeout.
- WAIT_EN = 0: mem_ready is ignored; every memory state takes 1 cycle.
- Reset asserted mid-access: FETCH on the next edge; mem_req and write enables deassert immediately after that edge.
- CPI with no waits: load 5; store, R, I and JAL 4; branch 3.

Decomposition:
- Package cu_pkg: state enum (4-bit), opcode constants, ALU-control codes, imm_src / src_a / src_b / result_src encodings.
- One sub-module, alu_decoder: combinational, takes op[5], funct3 and instr[30], returns alu_control. It is reused later by the pipelined core.

Test Plan:
- lw x5, 8(x1) with mem_ready delayed 2 cycles in FETCH and in MEMREAD -> states FETCH×3, DECODE, MEMADR, MEMREAD×3, MEMWB. reg_write = 1 only in MEMWB, with result_src = 01.
- sub x3, x1, x2 (funct7 = 0100000) -> alu_control = 010 in EXECR. ALUWB has reg_write = 1. 4 cycles total.
- beq with zf = 1, then bne with zf = 1 -> pc_write = 1 in BRANCH for beq, 0 for bne. Both return to FETCH.
- WAIT_MAX = 3, mem_ready held 0 in MEMWRITE -> timeout pulse on the 4th wait cycle. Next state FETCH; no reg_write asserted.
- Opcode 0110111 -> illegal pulses in DECODE. Next state FETCH; reg_write and mem_write stay 0.
- rst asserted during MEMREAD wait -> state_o = FETCH on the next edge, mem_req = 1 with adr_src = 0 thereafter.
